// File: rtl/rom_arb_pkg.sv
// Shared types and the round-robin pick function for the ROM burst arbiter
// and any other shared-resource controller built on rr_arbiter.
package rom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DRAIN = 2'd2
    } arb_state_t;

    // Widest requester vector supported; narrower users zero-extend into it.
    localparam int MAX_REQ = 8;

    // One-hot winner: first set bit of req scanning upward from ptr, modulo n.
    function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                   input logic [2:0]         ptr,
                                                   input int                 n);
        logic [MAX_REQ-1:0] win;
        logic               found;
        int                 idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (i < n && !found) begin
                idx = (int'(ptr) + i) % n;
                if (req[idx]) begin
                    win[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker with a registered priority pointer.
// The pointer moves just past the owner whenever the client says a grant retired.
module rr_arbiter
    import rom_arb_pkg::*;
#(
    parameter  int NUM_REQ  = 2,
    localparam int ID_WIDTH = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                advance,
    input  logic [ID_WIDTH-1:0] owner,
    output logic [NUM_REQ-1:0]  pick,
    output logic [ID_WIDTH-1:0] pick_id
);

    logic [ID_WIDTH-1:0] ptr_q;
    logic [MAX_REQ-1:0]  pick_wide;

    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (owner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end
    end

    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        pick_wide = rr_pick(MAX_REQ'(req), 3'(ptr_q), NUM_REQ);
        pick      = pick_wide[NUM_REQ-1:0];
        pick_id   = '0;
        for (int i = 0; i < MAX_REQ; i++) begin
            if (pick_wide[i]) begin
                pick_id = ID_WIDTH'(i);
            end
        end
    end

endmodule

// File: rtl/rom_burst_arbiter.sv
// Shares one synchronous-read parameter ROM between NUM_REQ layer engines:
// round-robin burst grants, ROM address generation, tagged data return.
module rom_burst_arbiter
    import rom_arb_pkg::*;
#(
    parameter  int DATA_WIDTH = 16,
    parameter  int DATA_DEPTH = 64,
    parameter  int NUM_REQ    = 2,
    parameter  int LEN_WIDTH  = 7,
    localparam int ADDR_WIDTH = $clog2(DATA_DEPTH),
    localparam int ID_WIDTH   = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   base_addr,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    burst_len,
    output logic [NUM_REQ-1:0]              grant,
    output logic                            rom_en,
    output logic [ADDR_WIDTH-1:0]           rom_addr,
    input  logic [DATA_WIDTH-1:0]           rom_data,
    output logic                            rd_valid,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [ID_WIDTH-1:0]             rd_id,
    output logic                            rd_last,
    output logic [NUM_REQ-1:0]              done,
    output logic                            err
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_EXT = (ADDR_WIDTH + 1)'(DATA_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

    arb_state_t            state_q, state_d;
    logic [NUM_REQ-1:0]    pick;
    logic [ID_WIDTH-1:0]   pick_id, owner_q;
    logic [ADDR_WIDTH-1:0] sel_base, addr_q;
    logic [LEN_WIDTH-1:0]  sel_len, remain_q;
    logic                  sel_bad, err_q, rd_valid_q;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .advance (state_q == DRAIN),
        .owner   (owner_q),
        .pick    (pick),
        .pick_id (pick_id)
    );

    always_comb begin
        sel_base = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_id == ID_WIDTH'(i)) begin
                sel_base = base_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_len  = burst_len[i*LEN_WIDTH +: LEN_WIDTH];
            end
        end
        sel_bad = ({1'b0, sel_base} >= DEPTH_EXT);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Zero-length and out-of-range bursts skip the ROM and retire through DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (|pick) state_d = (sel_bad || sel_len == '0) ? DRAIN : BURST;
            BURST:   if (remain_q == LEN_WIDTH'(1)) state_d = DRAIN;
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_q    <= '0;
            addr_q     <= '0;
            remain_q   <= '0;
            err_q      <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            // ROM output for the address issued this cycle appears next cycle.
            rd_valid_q <= (state_q == BURST);
            case (state_q)
                IDLE: begin
                    if (|pick) begin
                        owner_q  <= pick_id;
                        addr_q   <= sel_base;
                        remain_q <= sel_len;
                        err_q    <= sel_bad;
                    end
                end
                BURST: begin
                    addr_q   <= (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
                    remain_q <= remain_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // The last data beat always lands in DRAIN, so done/rd_last/err key off it.
    always_comb begin
        grant    = (state_q != IDLE) ? (NUM_REQ'(1) << owner_q) : '0;
        rom_en   = (state_q == BURST);
        rom_addr = rom_en ? addr_q : '0;
        rd_valid = rd_valid_q;
        rd_data  = rd_valid_q ? rom_data : '0;
        rd_id    = rd_valid_q ? owner_q : '0;
        rd_last  = rd_valid_q && (state_q == DRAIN);
        done     = (state_q == DRAIN) ? grant : '0;
        err      = (state_q == DRAIN) && err_q;
    end

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Table-driven bench for rom_burst_arbiter: a 64-word instance driven cycle by
// cycle from a vector table, plus a 48-word instance for bad-address and wrap.
module tb_rom_burst_arbiter;

    typedef struct packed {
        logic [1:0]  grant;
        logic        rom_en;
        logic [5:0]  rom_addr;
        logic        rd_valid;
        logic [15:0] rd_data;
        logic        rd_id;
        logic        rd_last;
        logic [1:0]  done;
        logic        err;
    } obs_t;

    typedef struct {
        logic       rst;
        logic [1:0] req;
        logic [5:0] base0, base1;
        logic [6:0] len0, len1;
        obs_t       exp;
    } vec_t;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: DATA_DEPTH 64
    logic        rst_a;
    logic [1:0]  req_a;
    logic [11:0] base_addr_a;
    logic [13:0] burst_len_a;
    logic [1:0]  grant_a, done_a;
    logic        rom_en_a, rd_valid_a, rd_id_a, rd_last_a, err_a;
    logic [5:0]  rom_addr_a;
    logic [15:0] rom_data_a, rd_data_a;

    // Instance B: DATA_DEPTH 48 (non-power-of-2, out-of-range addresses exist)
    logic        rst_b;
    logic [1:0]  req_b;
    logic [11:0] base_addr_b;
    logic [13:0] burst_len_b;
    logic [1:0]  grant_b, done_b;
    logic        rom_en_b, rd_valid_b, rd_id_b, rd_last_b, err_b;
    logic [5:0]  rom_addr_b;
    logic [15:0] rom_data_b, rd_data_b;

    rom_burst_arbiter #(.DATA_WIDTH(16), .DATA_DEPTH(64), .NUM_REQ(2), .LEN_WIDTH(7)) u_dut_a (
        .clk(clk), .rst(rst_a), .req(req_a), .base_addr(base_addr_a), .burst_len(burst_len_a),
        .grant(grant_a), .rom_en(rom_en_a), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
        .rd_valid(rd_valid_a), .rd_data(rd_data_a), .rd_id(rd_id_a), .rd_last(rd_last_a),
        .done(done_a), .err(err_a)
    );

    rom_burst_arbiter #(.DATA_WIDTH(16), .DATA_DEPTH(48), .NUM_REQ(2), .LEN_WIDTH(7)) u_dut_b (
        .clk(clk), .rst(rst_b), .req(req_b), .base_addr(base_addr_b), .burst_len(burst_len_b),
        .grant(grant_b), .rom_en(rom_en_b), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
        .rd_valid(rd_valid_b), .rd_data(rd_data_b), .rd_id(rd_id_b), .rd_last(rd_last_b),
        .done(done_b), .err(err_b)
    );

    // Synchronous-read ROM models: mem[i] = 16'h0100 + i
    always @(posedge clk) if (rom_en_a) rom_data_a <= 16'h0100 + 16'(rom_addr_a);
    always @(posedge clk) if (rom_en_b) rom_data_b <= 16'h0100 + 16'(rom_addr_b);

    int   n_checks = 0;
    int   n_pass   = 0;
    logic mon_en   = 1'b0;
    vec_t vecs[$];
    obs_t z;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic obs_t o(input int g, input int en, input int addr, input int v,
                               input int data, input int id, input int last, input int dn,
                               input int er);
        obs_t r;
        r.grant    = 2'(g);
        r.rom_en   = 1'(en);
        r.rom_addr = 6'(addr);
        r.rd_valid = 1'(v);
        r.rd_data  = 16'(data);
        r.rd_id    = 1'(id);
        r.rd_last  = 1'(last);
        r.done     = 2'(dn);
        r.err      = 1'(er);
        return r;
    endfunction

    function automatic void add(input int r, input int rq, input int b0, input int b1,
                                input int l0, input int l1, input obs_t e);
        vec_t v;
        v.rst   = 1'(r);
        v.req   = 2'(rq);
        v.base0 = 6'(b0);
        v.base1 = 6'(b1);
        v.len0  = 7'(l0);
        v.len1  = 7'(l1);
        v.exp   = e;
        vecs.push_back(v);
    endfunction

    function automatic obs_t sample_a();
        obs_t r;
        r.grant    = grant_a;
        r.rom_en   = rom_en_a;
        r.rom_addr = rom_addr_a;
        r.rd_valid = rd_valid_a;
        r.rd_data  = rd_data_a;
        r.rd_id    = rd_id_a;
        r.rd_last  = rd_last_a;
        r.done     = done_a;
        r.err      = err_a;
        return r;
    endfunction

    // Invariants: grant one-hot or zero, done only on the granted bit.
    always @(negedge clk) begin
        if (mon_en) begin
            check("grant_onehot_a", 64'($onehot0(grant_a)), 64'(1));
            check("done_in_grant_a", 64'(done_a & ~grant_a), 64'(0));
            check("grant_onehot_b", 64'($onehot0(grant_b)), 64'(1));
            check("done_in_grant_b", 64'(done_b & ~grant_b), 64'(0));
        end
    end

    initial begin
        logic [5:0]  addr_seen[$];
        logic [15:0] data_seen[$];
        logic [5:0]  exp_addr[4];
        logic [15:0] exp_data[4];
        int          k;

        z = o(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Row k inputs are applied before an edge; its outputs are those seen after it.
        // Reset state
        add(0, 0, 0, 0, 0, 0, z);
        add(0, 0, 0, 0, 0, 0, z);
        // Single burst: req0 base 5 len 4 (base/len change mid-burst is ignored)
        add(1, 1, 5, 0, 4, 0, o(1, 1, 5, 0, 0, 0, 0, 0, 0));
        add(1, 1, 5, 0, 4, 0, o(1, 1, 6, 1, 'h0105, 0, 0, 0, 0));
        add(1, 1, 30, 0, 1, 0, o(1, 1, 7, 1, 'h0106, 0, 0, 0, 0));
        add(1, 1, 30, 0, 1, 0, o(1, 1, 8, 1, 'h0107, 0, 0, 0, 0));
        add(1, 1, 5, 0, 4, 0, o(1, 0, 0, 1, 'h0108, 0, 1, 1, 0));
        add(1, 0, 5, 0, 4, 0, z);
        add(1, 0, 5, 0, 4, 0, z);
        // Simultaneous requests from reset, len 2 each; next grant at T+len+3
        add(0, 0, 0, 10, 2, 2, z);
        add(1, 3, 0, 10, 2, 2, o(1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(1, 3, 0, 10, 2, 2, o(1, 1, 1, 1, 'h0100, 0, 0, 0, 0));
        add(1, 3, 0, 10, 2, 2, o(1, 0, 0, 1, 'h0101, 0, 1, 1, 0));
        add(1, 3, 0, 10, 2, 2, z);
        add(1, 3, 0, 10, 2, 2, o(2, 1, 10, 0, 0, 0, 0, 0, 0));
        add(1, 3, 0, 10, 2, 2, o(2, 1, 11, 1, 'h010A, 1, 0, 0, 0));
        add(1, 3, 0, 10, 2, 2, o(2, 0, 0, 1, 'h010B, 1, 1, 2, 0));
        add(1, 3, 0, 10, 2, 2, z);
        add(1, 3, 0, 10, 2, 2, o(1, 1, 0, 0, 0, 0, 0, 0, 0));
        add(0, 3, 0, 10, 2, 2, z);
        // Wrap-around: base 62 len 4
        add(1, 1, 62, 0, 4, 0, o(1, 1, 62, 0, 0, 0, 0, 0, 0));
        add(1, 1, 62, 0, 4, 0, o(1, 1, 63, 1, 'h013E, 0, 0, 0, 0));
        add(1, 1, 62, 0, 4, 0, o(1, 1, 0, 1, 'h013F, 0, 0, 0, 0));
        add(1, 1, 62, 0, 4, 0, o(1, 1, 1, 1, 'h0100, 0, 0, 0, 0));
        add(1, 1, 62, 0, 4, 0, o(1, 0, 0, 1, 'h0101, 0, 1, 1, 0));
        add(1, 0, 62, 0, 4, 0, z);
        add(1, 0, 62, 0, 4, 0, z);
        // Zero length: done with grant on the first cycle, no ROM read
        add(1, 1, 7, 0, 0, 0, o(1, 0, 0, 0, 0, 0, 0, 1, 0));
        add(1, 0, 7, 0, 0, 0, z);
        // Reset at the 4th data beat of a len-10 burst, then req=11 goes to req0
        add(1, 1, 20, 0, 10, 0, o(1, 1, 20, 0, 0, 0, 0, 0, 0));
        add(1, 1, 20, 0, 10, 0, o(1, 1, 21, 1, 'h0114, 0, 0, 0, 0));
        add(1, 1, 20, 0, 10, 0, o(1, 1, 22, 1, 'h0115, 0, 0, 0, 0));
        add(1, 1, 20, 0, 10, 0, o(1, 1, 23, 1, 'h0116, 0, 0, 0, 0));
        add(1, 1, 20, 0, 10, 0, o(1, 1, 24, 1, 'h0117, 0, 0, 0, 0));
        add(0, 1, 20, 0, 10, 0, z);
        add(1, 3, 3, 9, 1, 1, o(1, 1, 3, 0, 0, 0, 0, 0, 0));
        add(1, 3, 3, 9, 1, 1, o(1, 0, 0, 1, 'h0103, 0, 1, 1, 0));
        add(1, 3, 3, 9, 1, 1, z);
        add(1, 3, 3, 9, 1, 1, o(2, 1, 9, 0, 0, 0, 0, 0, 0));
        add(1, 0, 3, 9, 1, 1, o(2, 0, 0, 1, 'h0109, 1, 1, 2, 0));
        add(1, 0, 3, 9, 1, 1, z);
        add(1, 0, 3, 9, 1, 1, z);

        rst_a = 1'b0; req_a = '0; base_addr_a = '0; burst_len_a = '0;
        rst_b = 1'b0; req_b = '0; base_addr_b = '0; burst_len_b = '0;
        tick();
        mon_en = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            rst_a       = vecs[i].rst;
            req_a       = vecs[i].req;
            base_addr_a = {vecs[i].base1, vecs[i].base0};
            burst_len_a = {vecs[i].len1, vecs[i].len0};
            tick();
            check($sformatf("vec%0d", i), 64'(sample_a()), 64'(vecs[i].exp));
        end

        // Fairness: req0 held high, req1 raised during req0's burst
        rst_a = 1'b0; req_a = 2'b00;
        tick();
        rst_a = 1'b1; req_a = 2'b01;
        base_addr_a = {6'd10, 6'd0}; burst_len_a = {7'd2, 7'd3};
        tick();
        tick();
        req_a = 2'b11;
        k = 0;
        while (done_a[0] !== 1'b1 && k < 20) begin tick(); k++; end
        check("fair_done0", 64'(done_a), 64'(2'b01));
        tick();
        check("fair_dead_cycle", 64'(grant_a), 64'(0));
        tick();
        check("fair_grant1", 64'(grant_a), 64'(2'b10));
        k = 0;
        while (done_a[1] !== 1'b1 && k < 20) begin tick(); k++; end
        check("fair_done1", 64'(done_a), 64'(2'b10));
        tick();
        tick();
        check("fair_regrant0", 64'(grant_a), 64'(2'b01));
        req_a = 2'b00;
        k = 0;
        while (done_a[0] !== 1'b1 && k < 20) begin tick(); k++; end
        tick();
        tick();

        // Depth 48: base 50 is out of range -> err + done, no ROM read
        tick();
        rst_b = 1'b1; req_b = 2'b01;
        base_addr_b = {6'd0, 6'd50}; burst_len_b = {7'd0, 7'd3};
        tick();
        check("bad_addr_err", 64'(err_b), 64'(1));
        check("bad_addr_done", 64'(done_b), 64'(2'b01));
        check("bad_addr_grant", 64'(grant_b), 64'(2'b01));
        check("bad_addr_rom_en", 64'(rom_en_b), 64'(0));
        req_b = 2'b00;
        tick();
        check("bad_addr_after", 64'({grant_b, err_b, done_b}), 64'(0));

        // Depth 48 wrap: base 46 len 4 -> 46,47,0,1
        req_b = 2'b01;
        base_addr_b = {6'd0, 6'd46}; burst_len_b = {7'd0, 7'd4};
        exp_addr = '{6'd46, 6'd47, 6'd0, 6'd1};
        exp_data = '{16'h012E, 16'h012F, 16'h0100, 16'h0101};
        for (int c = 0; c < 12; c++) begin
            tick();
            if (rom_en_b) addr_seen.push_back(rom_addr_b);
            if (rd_valid_b) data_seen.push_back(rd_data_b);
            if (done_b[0]) req_b = 2'b00;
        end
        check("wrap48_addr_count", 64'(addr_seen.size()), 64'(4));
        check("wrap48_data_count", 64'(data_seen.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            check($sformatf("wrap48_addr%0d", i),
                  64'((i < addr_seen.size()) ? addr_seen[i] : 6'h3F), 64'(exp_addr[i]));
            check($sformatf("wrap48_data%0d", i),
                  64'((i < data_seen.size()) ? data_seen[i] : 16'hFFFF), 64'(exp_data[i]));
        end

        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
